// File: rtl/cell_comm_tx_arbiter.sv
// Packet-atomic arbiter merging local FA packets and forwarded packets onto the Aurora TX stream.
// Forward-stall watchdog closes broken packets with an invalid marker; link loss drains the active source.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | between packets; grant decision, or discard both while link down
// LOC      | local packet passed through to tx
// FW       | forwarded packet passed through to tx, stall watchdog running
// TERM     | emitting the invalid-marker beat that closes a stalled fw packet
// DRAIN    | consuming the rest of a broken packet from drainFw's source
module cell_comm_tx_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int WATCHDOG_WIDTH  = 6,
  parameter int ABORT_CNT_WIDTH = 16
) (
  input  logic                       txClk,
  input  logic                       txReset,
  input  logic                       txAuroraChannelUp,
  input  logic                       locValid,
  input  logic                       locLast,
  input  logic [DATA_WIDTH-1:0]      locData,
  output logic                       locReady,
  input  logic                       fwValid,
  input  logic                       fwLast,
  input  logic [DATA_WIDTH-1:0]      fwData,
  output logic                       fwReady,
  output logic                       txValid,
  output logic                       txLast,
  output logic [DATA_WIDTH-1:0]      txData,
  input  logic                       txReady,
  output logic [ABORT_CNT_WIDTH-1:0] fwAbortCount
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOC   = 3'd1;
  localparam logic [2:0] ST_FW    = 3'd2;
  localparam logic [2:0] ST_TERM  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  localparam logic [WATCHDOG_WIDTH-1:0]  WD_LOAD      = '1;
  localparam logic [WATCHDOG_WIDTH-1:0]  WD_ONE       = {{(WATCHDOG_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0]      INVALID_MARK = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [ABORT_CNT_WIDTH-1:0] ABORT_MAX    = '1;

  logic [2:0]                state;
  logic                      lastGrantFw;
  logic                      drainFw;
  logic [WATCHDOG_WIDTH-1:0] watchdog;
  logic                      locAccept;
  logic                      fwAccept;
  logic                      wdExpire;

  assign locAccept = locValid && locReady;
  assign fwAccept  = fwValid && fwReady;
  // Terminal count: the idle cycle that would take the watchdog from 1 to 0.
  assign wdExpire  = !fwValid && (watchdog == WD_ONE);

  always_comb begin
    txValid  = 1'b0;
    txLast   = 1'b0;
    txData   = '0;
    locReady = 1'b0;
    fwReady  = 1'b0;
    if (!txReset) begin
      case (state)
        ST_IDLE: begin
          if (!txAuroraChannelUp) begin
            locReady = 1'b1;
            fwReady  = 1'b1;
          end
        end
        ST_LOC: begin
          txValid  = locValid;
          txLast   = locLast;
          txData   = locData;
          locReady = txReady;
        end
        ST_FW: begin
          txValid = fwValid;
          txLast  = fwLast;
          txData  = fwData;
          fwReady = txReady;
        end
        ST_TERM: begin
          txValid = 1'b1;
          txLast  = 1'b1;
          txData  = INVALID_MARK;
        end
        ST_DRAIN: begin
          if (drainFw) fwReady = 1'b1;
          else         locReady = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge txClk) begin
    if (txReset) begin
      state        <= ST_IDLE;
      lastGrantFw  <= 1'b1;
      drainFw      <= 1'b0;
      watchdog     <= WD_LOAD;
      fwAbortCount <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (txAuroraChannelUp) begin
            if (locValid && (!fwValid || lastGrantFw)) begin
              state <= ST_LOC;
            end else if (fwValid) begin
              state    <= ST_FW;
              watchdog <= WD_LOAD;
            end
          end
        end
        ST_LOC: begin
          if (locAccept && locLast) begin
            state       <= ST_IDLE;
            lastGrantFw <= 1'b0;
          end else if (!txAuroraChannelUp) begin
            state   <= ST_DRAIN;
            drainFw <= 1'b0;
          end
        end
        ST_FW: begin
          if (fwAccept && fwLast) begin
            state       <= ST_IDLE;
            lastGrantFw <= 1'b1;
          end else if (!txAuroraChannelUp) begin
            state    <= ST_DRAIN;
            drainFw  <= 1'b1;
            watchdog <= WD_LOAD;
          end else if (fwAccept) begin
            watchdog <= WD_LOAD;
          end else if (!fwValid) begin
            // Output back-pressure with fwValid high holds the watchdog.
            if (wdExpire) begin
              state <= ST_TERM;
              if (fwAbortCount != ABORT_MAX) fwAbortCount <= fwAbortCount + 1'b1;
            end else begin
              watchdog <= watchdog - 1'b1;
            end
          end
        end
        ST_TERM: begin
          if (txReady || !txAuroraChannelUp) begin
            state    <= ST_DRAIN;
            drainFw  <= 1'b1;
            watchdog <= WD_LOAD;
          end
        end
        ST_DRAIN: begin
          if (drainFw) begin
            if ((fwAccept && fwLast) || wdExpire) begin
              state       <= ST_IDLE;
              lastGrantFw <= 1'b1;
            end else if (fwAccept) begin
              watchdog <= WD_LOAD;
            end else begin
              watchdog <= watchdog - 1'b1;
            end
          end else if (locAccept && locLast) begin
            state       <= ST_IDLE;
            lastGrantFw <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_comm_tx_arbiter.sv
// Self-checking bench for cell_comm_tx_arbiter: vector table, hand-written corner sequences,
// and randomized two-source traffic checked against a packet-level scoreboard.
module tb_cell_comm_tx_arbiter;

  logic        txClk = 1'b0;
  logic        txReset = 1'b1;
  logic        chUp = 1'b0;
  logic        locValid = 1'b0, locLast = 1'b0, fwValid = 1'b0, fwLast = 1'b0, txReady = 1'b0;
  logic [31:0] locData = '0, fwData = '0;
  logic        locReady, fwReady, txValid, txLast;
  logic [31:0] txData;
  logic [15:0] fwAbortCount;
  logic        locReady2, fwReady2, txValid2, txLast2;
  logic [31:0] txData2;
  logic [2:0]  abort2;

  int checks = 0;
  int fails  = 0;

  always #5 txClk = ~txClk;

  cell_comm_tx_arbiter dut (
    .txClk(txClk), .txReset(txReset), .txAuroraChannelUp(chUp),
    .locValid(locValid), .locLast(locLast), .locData(locData), .locReady(locReady),
    .fwValid(fwValid), .fwLast(fwLast), .fwData(fwData), .fwReady(fwReady),
    .txValid(txValid), .txLast(txLast), .txData(txData), .txReady(txReady),
    .fwAbortCount(fwAbortCount)
  );

  // Small-parameter copy sharing the same inputs, used for abort-counter saturation.
  cell_comm_tx_arbiter #(.DATA_WIDTH(32), .WATCHDOG_WIDTH(2), .ABORT_CNT_WIDTH(3)) dutSmall (
    .txClk(txClk), .txReset(txReset), .txAuroraChannelUp(chUp),
    .locValid(locValid), .locLast(locLast), .locData(locData), .locReady(locReady2),
    .fwValid(fwValid), .fwLast(fwLast), .fwData(fwData), .fwReady(fwReady2),
    .txValid(txValid2), .txLast(txLast2), .txData(txData2), .txReady(txReady),
    .fwAbortCount(abort2)
  );

  typedef struct {
    logic rst, up, lv, ll; logic [31:0] ld;
    logic fv, fl; logic [31:0] fd; logic rdy;
    logic eV, eL; logic [31:0] eD; logic eLR, eFR;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(input logic rst, up, lv, ll, input logic [31:0] ld,
                              input logic fv, fl, input logic [31:0] fd, input logic rdy,
                              input logic eV, eL, input logic [31:0] eD, input logic eLR, eFR);
    vec_t v;
    v.rst = rst; v.up = up; v.lv = lv; v.ll = ll; v.ld = ld;
    v.fv = fv; v.fl = fl; v.fd = fd; v.rdy = rdy;
    v.eV = eV; v.eL = eL; v.eD = eD; v.eLR = eLR; v.eFR = eFR;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later, far from the rising edge.
  task automatic drive(input logic rst, up, lv, ll, input logic [31:0] ld,
                       input logic fv, fl, input logic [31:0] fd, input logic rdy);
    @(negedge txClk);
    txReset = rst; chUp = up;
    locValid = lv; locLast = ll; locData = ld;
    fwValid = fv; fwLast = fl; fwData = fd; txReady = rdy;
    #1;
  endtask

  task automatic expectOut(input string name, input logic v, l, input logic [31:0] d,
                           input logic lr, fr);
    check(name, 64'({txValid, txLast, txData, locReady, fwReady}), 64'({v, l, d, lr, fr}));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int found;
    logic ok;
    logic acc;
    logic [31:0] locW[$], fwW[$], expLocW[$], expFwW[$];
    logic        locL[$], fwL[$], expLocL[$], expFwL[$];
    int lp, fp, cur, fgap, seq;
    logic lvh, fvh, pV, pR, pL, bubbleNext, lv, fv, rdy;
    logic [31:0] pD;

    // rst up lv ll ld            fv fl fd            rdy | eV eL eD           eLR eFR
    tbl[0]  = mk(1, 1, 1, 0, 32'hA0000000, 1, 0, 32'h50000000, 1,  0, 0, 32'h0,        0, 0);
    tbl[1]  = mk(0, 1, 1, 0, 32'hA0000000, 0, 0, 32'h0,        1,  0, 0, 32'h0,        0, 0);
    tbl[2]  = mk(0, 1, 1, 0, 32'hA0000000, 0, 0, 32'h0,        1,  1, 0, 32'hA0000000, 1, 0);
    tbl[3]  = mk(0, 1, 1, 0, 32'hA0000001, 0, 0, 32'h0,        1,  1, 0, 32'hA0000001, 1, 0);
    tbl[4]  = mk(0, 1, 1, 0, 32'hA0000002, 0, 0, 32'h0,        1,  1, 0, 32'hA0000002, 1, 0);
    tbl[5]  = mk(0, 1, 1, 1, 32'hA0000003, 0, 0, 32'h0,        1,  1, 1, 32'hA0000003, 1, 0);
    tbl[6]  = mk(0, 1, 1, 1, 32'hA0000004, 1, 0, 32'h50000000, 1,  0, 0, 32'h0,        0, 0);
    tbl[7]  = mk(0, 1, 1, 1, 32'hA0000004, 1, 0, 32'h50000000, 1,  1, 0, 32'h50000000, 0, 1);
    tbl[8]  = mk(0, 1, 1, 1, 32'hA0000004, 1, 1, 32'h50000001, 1,  1, 1, 32'h50000001, 0, 1);
    tbl[9]  = mk(0, 1, 1, 1, 32'hA0000004, 1, 0, 32'h50000002, 1,  0, 0, 32'h0,        0, 0);
    tbl[10] = mk(0, 1, 1, 1, 32'hA0000004, 1, 0, 32'h50000002, 0,  1, 1, 32'hA0000004, 0, 0);
    tbl[11] = mk(0, 1, 1, 1, 32'hA0000004, 1, 0, 32'h50000002, 1,  1, 1, 32'hA0000004, 1, 0);
    tbl[12] = mk(1, 1, 1, 1, 32'hA0000005, 1, 1, 32'h50000002, 1,  0, 0, 32'h0,        0, 0);
    tbl[13] = mk(0, 1, 1, 1, 32'hA0000005, 1, 1, 32'h50000002, 1,  0, 0, 32'h0,        0, 0);
    tbl[14] = mk(0, 1, 1, 1, 32'hA0000005, 1, 1, 32'h50000002, 1,  1, 1, 32'hA0000005, 1, 0);
    tbl[15] = mk(0, 1, 1, 1, 32'hA0000006, 1, 1, 32'h50000002, 1,  0, 0, 32'h0,        0, 0);
    tbl[16] = mk(0, 1, 1, 1, 32'hA0000006, 1, 1, 32'h50000002, 1,  1, 1, 32'h50000002, 0, 1);
    tbl[17] = mk(0, 1, 1, 1, 32'hA0000006, 1, 1, 32'h50000003, 1,  0, 0, 32'h0,        0, 0);
    tbl[18] = mk(0, 1, 1, 1, 32'hA0000006, 1, 1, 32'h50000003, 1,  1, 1, 32'hA0000006, 1, 0);
    tbl[19] = mk(0, 0, 1, 1, 32'hA0000007, 1, 1, 32'h50000004, 1,  0, 0, 32'h0,        1, 1);
    tbl[20] = mk(0, 0, 1, 1, 32'hA0000007, 1, 1, 32'h50000004, 1,  0, 0, 32'h0,        1, 1);
    tbl[21] = mk(0, 1, 0, 0, 32'h0,        1, 1, 32'h50000005, 1,  0, 0, 32'h0,        0, 0);
    tbl[22] = mk(0, 1, 0, 0, 32'h0,        1, 1, 32'h50000005, 1,  1, 1, 32'h50000005, 0, 1);
    tbl[23] = mk(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        1,  0, 0, 32'h0,        0, 0);
    tbl[24] = mk(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        1,  0, 0, 32'h0,        0, 0);

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].rst, tbl[i].up, tbl[i].lv, tbl[i].ll, tbl[i].ld,
            tbl[i].fv, tbl[i].fl, tbl[i].fd, tbl[i].rdy);
      expectOut($sformatf("vec%0d", i), tbl[i].eV, tbl[i].eL, tbl[i].eD, tbl[i].eLR, tbl[i].eFR);
    end
    check("vec_abort", 64'(fwAbortCount), 64'(0));

    // Long output stall inside a forwarded packet must not trip the watchdog.
    drive(1, 1, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 1, 0, 32'h50000100, 1); expectOut("stall_idle", 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 1, 0, 32'h50000100, 1); expectOut("stall_b0", 1, 0, 32'h50000100, 0, 1);
    drive(0, 1, 0, 0, 0, 1, 0, 32'h50000101, 1); expectOut("stall_b1", 1, 0, 32'h50000101, 0, 1);
    ok = 1'b1;
    repeat (100) begin
      drive(0, 1, 0, 0, 0, 1, 0, 32'h50000102, 0);
      if ({txValid, txLast, txData, fwReady} !== {1'b1, 1'b0, 32'h50000102, 1'b0}) ok = 1'b0;
    end
    check("stall_hold", 64'(ok), 64'(1));
    drive(0, 1, 0, 0, 0, 1, 0, 32'h50000102, 1); expectOut("stall_b2", 1, 0, 32'h50000102, 0, 1);
    drive(0, 1, 0, 0, 0, 1, 1, 32'h50000103, 1); expectOut("stall_b3", 1, 1, 32'h50000103, 0, 1);
    check("stall_abort", 64'(fwAbortCount), 64'(0));

    // Forwarded packet goes quiet after two beats: invalid marker after 63 idle cycles.
    drive(1, 1, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 1, 0, 32'h50000A00, 1); expectOut("wd_idle", 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 1, 0, 32'h50000A00, 1); expectOut("wd_b0", 1, 0, 32'h50000A00, 0, 1);
    drive(0, 1, 0, 0, 0, 1, 0, 32'h50000A01, 1); expectOut("wd_b1", 1, 0, 32'h50000A01, 0, 1);
    found = 0;
    for (int i = 1; i <= 200 && found == 0; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0, 1);
      if (txValid) found = i;
    end
    check("wd_delay", 64'(found), 64'(64));
    expectOut("term_beat", 1, 1, 32'h80000000, 0, 0);
    check("abort_one", 64'(fwAbortCount), 64'(1));
    drive(0, 1, 0, 0, 0, 1, 0, 32'h50000A02, 1); expectOut("drain_b2", 0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 1, 1, 32'h50000A03, 1); expectOut("drain_b3", 0, 0, 0, 0, 1);
    drive(0, 1, 1, 0, 32'hA0000B00, 0, 0, 0, 1); expectOut("post_idle", 0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 32'hA0000B00, 0, 0, 0, 1); expectOut("post_k0", 1, 0, 32'hA0000B00, 1, 0);
    drive(0, 1, 1, 1, 32'hA0000B01, 0, 0, 0, 1); expectOut("post_k1", 1, 1, 32'hA0000B01, 1, 0);
    check("abort_still_one", 64'(fwAbortCount), 64'(1));

    // Link drop on local beat 2, then link-down discard in IDLE.
    drive(1, 1, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 1, 1, 0, 32'hA0000C00, 0, 0, 0, 1); expectOut("drop_idle", 0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 32'hA0000C00, 0, 0, 0, 1); expectOut("drop_m0", 1, 0, 32'hA0000C00, 1, 0);
    drive(0, 0, 1, 0, 32'hA0000C01, 0, 0, 0, 1); expectOut("drop_m1", 1, 0, 32'hA0000C01, 1, 0);
    drive(0, 0, 1, 0, 32'hA0000C02, 0, 0, 0, 1); expectOut("drop_m2", 0, 0, 0, 1, 0);
    drive(0, 0, 1, 1, 32'hA0000C03, 0, 0, 0, 1); expectOut("drop_m3", 0, 0, 0, 1, 0);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 0, 1, (i % 2 == 1), 32'h50000D00 + i, 1);
      if ({txValid, txLast} !== 2'b00 || fwReady !== 1'b1 || locReady !== 1'b1) ok = 1'b0;
    end
    check("linkdown_discard", 64'(ok), 64'(1));

    // Abort counter saturation on the small-parameter instance (max 7).
    drive(1, 1, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 10; k++) begin
      acc = 1'b0;
      for (int t = 0; t < 10 && !acc; t++) begin
        drive(0, 1, 0, 0, 0, 1, 0, 32'h50000E00 + k, 1);
        if (fwReady2) acc = 1'b1;
      end
      repeat (20) drive(0, 1, 0, 0, 0, 0, 0, 0, 1);
      check($sformatf("abort_sat_%0d", k), 64'(abort2), 64'((k < 7) ? k : 7));
    end

    // Randomized traffic: tx stream must be whole packets, in per-source order.
    seq = 0;
    for (int p = 0; p < 30; p++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        locW.push_back(32'hA0000000 | seq); locL.push_back(b == len - 1); seq++;
      end
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        fwW.push_back(32'h50000000 | seq); fwL.push_back(b == len - 1); seq++;
      end
    end
    expLocW = locW; expLocL = locL; expFwW = fwW; expFwL = fwL;
    lp = 0; fp = 0; cur = 0; fgap = 0;
    lvh = 0; fvh = 0; pV = 0; pR = 0; pL = 0; pD = '0; bubbleNext = 0;
    drive(1, 1, 0, 0, 0, 0, 0, 0, 1);
    for (int cyc = 0; cyc < 20000 && (expLocW.size() != 0 || expFwW.size() != 0); cyc++) begin
      lv  = lvh || (lp < locW.size() && $urandom_range(0, 9) < 6);
      fv  = fvh || (fp < fwW.size() && ($urandom_range(0, 9) < 6 || fgap >= 20));
      rdy = ($urandom_range(0, 3) != 0);
      drive(0, 1, lv, (lp < locW.size()) ? locL[lp] : 1'b0, (lp < locW.size()) ? locW[lp] : 32'h0,
            fv, (fp < fwW.size()) ? fwL[fp] : 1'b0, (fp < fwW.size()) ? fwW[fp] : 32'h0, rdy);
      if (pV && !pR) check("axi_hold", 64'({txValid, txLast, txData}), 64'({1'b1, pL, pD}));
      if (bubbleNext) check("bubble", 64'(txValid), 64'(0));
      bubbleNext = 0;
      if (txValid && txReady) begin
        if (cur == 0) cur = (txData[31:28] == 4'hA) ? 1 : (txData[31:28] == 4'h5) ? 2 : 3;
        if (cur == 1 && expLocW.size() != 0) begin
          check("rand_loc_beat", 64'({txLast, txData}), 64'({expLocL[0], expLocW[0]}));
          void'(expLocW.pop_front()); void'(expLocL.pop_front());
        end else if (cur == 2 && expFwW.size() != 0) begin
          check("rand_fw_beat", 64'({txLast, txData}), 64'({expFwL[0], expFwW[0]}));
          void'(expFwW.pop_front()); void'(expFwL.pop_front());
        end else begin
          checks++; fails++;
          $display("FAIL rand_unexpected_beat: got 0x%0h, expected no beat", txData);
        end
        if (txLast) begin cur = 0; bubbleNext = 1; end
      end
      if (lv && locReady) begin lp++; lvh = 0; end else lvh = lv;
      if (fv && fwReady) begin fp++; fvh = 0; end else fvh = fv;
      fgap = fv ? 0 : fgap + 1;
      pV = txValid; pR = txReady; pL = txLast; pD = txData;
    end
    check("rand_loc_left", 64'(expLocW.size()), 64'(0));
    check("rand_fw_left", 64'(expFwW.size()), 64'(0));
    check("rand_abort", 64'(fwAbortCount), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
